// File: rtl/line_fill_controller.sv
// line_fill_controller
//
// Write-side sequencer for the ping-pong row buffer. Each line_start swaps
// the buffers (toggles select), latches the row to fill, then requests one
// full row of 4-bit palette indices from the fixed-latency pixel source.
// The returned indices are streamed into the idle buffer, one per cycle.
//
// Source timing: a request launched on clock edge e (src_X/src_Y registered
// at e) has its data sampled by this block on edge e + SRC_LATENCY. The
// delay line carries the matching valid bit and column alongside it.
//
// Ports
//   Clk50       in   system clock
//   Reset       in   asynchronous active-low reset
//   line_start  in   one-cycle pulse: a new display row has begun
//   next_row    in   row to fill, sampled only with line_start
//   src_data    in   palette index returned by the pixel source
//   src_X/src_Y out  pixel-source column/row request
//   write_en    out  row-buffer write strobe
//   write_X     out  row-buffer write column
//   write_Y     out  row currently being filled
//   write_data  out  row-buffer write data
//   select      out  buffer-swap control
//   busy        out  high while filling or draining
//   overrun     out  one-cycle pulse when a fill is aborted by line_start
//
// Handshake: there is no back-pressure. line_start is a single-cycle
// request accepted in any state; write_en qualifies write_X/write_data
// for exactly the cycle it is high, and the row buffer must accept it.

module line_fill_controller #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int SRC_LATENCY = 2
) (
    input  logic       Clk50,
    input  logic       Reset,
    input  logic       line_start,
    input  logic [9:0] next_row,
    input  logic [3:0] src_data,
    output logic [9:0] src_X,
    output logic [9:0] src_Y,
    output logic       write_en,
    output logic [9:0] write_X,
    output logic [9:0] write_Y,
    output logic [3:0] write_data,
    output logic       select,
    output logic       busy,
    output logic       overrun
);

    localparam logic [9:0] H_LAST  = 10'(H_PIXELS - 1);
    localparam logic [9:0] V_LIMIT = 10'(V_LINES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    // Delay line: stage 0 is loaded on the edge that launches a request;
    // the last stage lines up with src_data for that request.
    logic [SRC_LATENCY-1:0] dl_valid;
    logic [9:0]             dl_col [SRC_LATENCY];

    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            src_X      <= '0;
            src_Y      <= '0;
            write_en   <= 1'b0;
            write_X    <= '0;
            write_Y    <= '0;
            write_data <= '0;
            select     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            dl_valid   <= '0;
            for (int i = 0; i < SRC_LATENCY; i++) begin
                dl_col[i] <= '0;
            end
        end else begin
            overrun <= 1'b0;

            // Default: advance the delay line, nothing new enters.
            for (int i = SRC_LATENCY - 1; i > 0; i--) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_col[i]   <= dl_col[i-1];
            end
            dl_valid[0] <= 1'b0;
            dl_col[0]   <= '0;

            if (line_start) begin
                // Buffer swap. Anything still in flight belongs to the old
                // buffer, so it is dropped and no write happens this edge,
                // keeping write_en low whenever select changes.
                select   <= ~select;
                write_Y  <= next_row;
                src_Y    <= next_row;
                src_X    <= '0;
                write_en <= 1'b0;
                dl_valid <= '0;
                if (state != IDLE) begin
                    overrun <= 1'b1;
                end
                if (next_row < V_LIMIT) begin
                    state       <= FILL;
                    busy        <= 1'b1;
                    dl_valid[0] <= 1'b1;
                    dl_col[0]   <= '0;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                // Write port: data returned for the oldest request.
                if (dl_valid[SRC_LATENCY-1]) begin
                    write_en   <= 1'b1;
                    write_X    <= dl_col[SRC_LATENCY-1];
                    write_data <= src_data;
                end else begin
                    write_en <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        src_X <= '0;
                        busy  <= 1'b0;
                    end
                    FILL: begin
                        if (src_X == H_LAST) begin
                            // Last column was issued; wait for its data.
                            state <= DRAIN;
                            src_X <= '0;
                        end else begin
                            src_X       <= src_X + 10'd1;
                            dl_valid[0] <= 1'b1;
                            dl_col[0]   <= src_X + 10'd1;
                        end
                    end
                    DRAIN: begin
                        if (dl_valid == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        src_X <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_fill_controller.sv
// Bench for line_fill_controller: two instances (source latency 2 and 4)
// share clock, reset and line_start. A timeline model derives expected
// outputs from the pulse times and rows; a source model returns
// src_X[3:0] with the fixed latency.

module tb_line_fill_controller;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int LAT0 = 2;
    localparam int LAT1 = 4;

    logic       Clk50      = 1'b0;
    logic       Reset      = 1'b1;
    logic       line_start = 1'b0;
    logic [9:0] next_row   = 10'd0;

    logic [3:0] src_d [2] = '{4'd0, 4'd0};
    logic [9:0] src_x [2];
    logic [9:0] src_y [2];
    logic       wr_en [2];
    logic [9:0] wr_x  [2];
    logic [9:0] wr_y  [2];
    logic [3:0] wr_d  [2];
    logic       sel   [2];
    logic       busy  [2];
    logic       ovr   [2];

    int tests = 0;
    int fails = 0;

    // ---------------- clock ----------------
    always #10 Clk50 = ~Clk50;

    // ---------------- DUTs ----------------
    line_fill_controller #(.H_PIXELS(H), .V_LINES(V), .SRC_LATENCY(LAT0)) u_dut_l2 (
        .Clk50(Clk50), .Reset(Reset), .line_start(line_start), .next_row(next_row),
        .src_data(src_d[0]), .src_X(src_x[0]), .src_Y(src_y[0]),
        .write_en(wr_en[0]), .write_X(wr_x[0]), .write_Y(wr_y[0]),
        .write_data(wr_d[0]), .select(sel[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    line_fill_controller #(.H_PIXELS(H), .V_LINES(V), .SRC_LATENCY(LAT1)) u_dut_l4 (
        .Clk50(Clk50), .Reset(Reset), .line_start(line_start), .next_row(next_row),
        .src_data(src_d[1]), .src_X(src_x[1]), .src_Y(src_y[1]),
        .write_en(wr_en[1]), .write_X(wr_x[1]), .write_Y(wr_y[1]),
        .write_data(wr_d[1]), .select(sel[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    // ---------------- pixel source ----------------
    // hist[i][j] holds the src_X seen j cycles ago; data for a request is
    // sampled by the DUT LAT edges after the edge that launched it.
    logic [9:0] hist [2][4] = '{default: 10'd0};

    always @(posedge Clk50) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = src_x[i];
        end
        src_d[0] = hist[0][LAT0-1][3:0];
        src_d[1] = hist[1][LAT1-1][3:0];
    end

    // ---------------- timeline model ----------------
    int         edge_n = 0;
    int         last_pulse = 0;
    bit         m_active [2] = '{0, 0};
    int         m_start  [2] = '{0, 0};
    logic       e_sel  [2] = '{0, 0};
    logic       e_busy [2] = '{0, 0};
    logic       e_ovr  [2] = '{0, 0};
    logic       e_wen  [2] = '{0, 0};
    logic [9:0] e_wx   [2] = '{10'd0, 10'd0};
    logic [9:0] e_wy   [2] = '{10'd0, 10'd0};
    logic [9:0] e_sx   [2] = '{10'd0, 10'd0};
    logic [3:0] e_wd   [2] = '{4'd0, 4'd0};

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            e_sel[i] = 0; e_busy[i] = 0; e_ovr[i] = 0; e_wen[i] = 0;
            e_wx[i] = 0;  e_wy[i] = 0;   e_sx[i] = 0;  e_wd[i] = 0;
        end
    endtask

    // Expected outputs after clock edge edge_n, from pulse time and row only.
    task automatic model_step(input int i);
        int lat;
        int k;
        int d;
        lat = (i == 0) ? LAT0 : LAT1;
        if (line_start) begin
            e_ovr[i]    = e_busy[i];
            e_sel[i]    = ~e_sel[i];
            e_wy[i]     = next_row;
            m_active[i] = (next_row < 10'(V));
            m_start[i]  = edge_n;
            e_wen[i]    = 1'b0;
        end else begin
            e_ovr[i] = 1'b0;
            k = edge_n - m_start[i] - lat;
            if (m_active[i] && k >= 0 && k < H) begin
                e_wen[i] = 1'b1;
                e_wx[i]  = 10'(k);
                e_wd[i]  = 4'(k % 16);
            end else begin
                e_wen[i] = 1'b0;
            end
        end
        d = edge_n - m_start[i];
        if (m_active[i] && d >= lat + H) m_active[i] = 0;
        e_busy[i] = m_active[i];
        e_sx[i]   = (m_active[i] && d < H) ? 10'(d) : 10'd0;
    endtask

    bit first_seen [2] = '{1, 1};

    always @(negedge Reset) model_clear();

    always @(posedge Clk50) begin
        edge_n++;
        if (Reset) begin
            if (line_start) begin
                last_pulse = edge_n;
                first_seen[0] = 0;
                first_seen[1] = 0;
            end
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- scoreboard / compare ----------------
    int         wr_cnt    [2] = '{0, 0};
    int         ovr_cnt   [2] = '{0, 0};
    bit         busy_seen [2] = '{0, 0};
    bit         busy_prev [2] = '{0, 0};
    int         first_lat [2] = '{0, 0};
    int         fall_lat  [2] = '{0, 0};
    logic [9:0] first_x   [2] = '{10'd0, 10'd0};

    always @(negedge Clk50) begin
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (sel[i] !== e_sel[i] || busy[i] !== e_busy[i] || ovr[i] !== e_ovr[i] ||
                wr_en[i] !== e_wen[i] || wr_x[i] !== e_wx[i] || wr_y[i] !== e_wy[i] ||
                wr_d[i] !== e_wd[i] || src_x[i] !== e_sx[i] || src_y[i] !== e_wy[i]) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL cycle_check dut%0d edge %0d: got sel=%b busy=%b ovr=%b wen=%b wx=%0d wy=%0d wd=%0d sx=%0d sy=%0d; want sel=%b busy=%b ovr=%b wen=%b wx=%0d wy=%0d wd=%0d sx=%0d sy=%0d",
                             i, edge_n, sel[i], busy[i], ovr[i], wr_en[i], wr_x[i], wr_y[i], wr_d[i], src_x[i], src_y[i],
                             e_sel[i], e_busy[i], e_ovr[i], e_wen[i], e_wx[i], e_wy[i], e_wd[i], e_sx[i], e_wy[i]);
            end
            if (wr_en[i] === 1'b1) wr_cnt[i]++;
            if (ovr[i] === 1'b1) ovr_cnt[i]++;
            if (busy[i] === 1'b1) busy_seen[i] = 1;
            if (wr_en[i] === 1'b1 && !first_seen[i]) begin
                first_seen[i] = 1;
                first_lat[i]  = edge_n - last_pulse + 1;
                first_x[i]    = wr_x[i];
            end
            if (busy_prev[i] && busy[i] === 1'b0) fall_lat[i] = edge_n - last_pulse + 1;
            busy_prev[i] = (busy[i] === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [9:0] row);
        @(negedge Clk50);
        line_start = 1'b1;
        next_row   = row;
        @(negedge Clk50);
        line_start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk50);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; ovr_cnt[i] = 0; busy_seen[i] = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk50);
        #1;
        check("reset_select",   32'(sel[0]),   0);
        check("reset_write_en", 32'(wr_en[0]), 0);
        check("reset_busy",     32'(busy[1]),  0);
        check("reset_write_y",  32'(wr_y[0]),  0);
        @(negedge Clk50);
        Reset = 1'b1;

        // Row 5, then row 6 one line period later.
        clear_counts();
        pulse(10'd5);
        wait_cycles(1598);
        check("row5_select",       32'(sel[0]),  1);
        check("row5_first_lat_l2", first_lat[0], 3);
        check("row5_first_lat_l4", first_lat[1], 5);
        check("row5_first_x",      32'(first_x[0]), 0);
        check("row5_busy_fall_l2", fall_lat[0], 643);
        check("row5_busy_fall_l4", fall_lat[1], 645);
        check("row5_writes_l2",    wr_cnt[0], 640);
        check("row5_writes_l4",    wr_cnt[1], 640);
        check("row5_overrun",      ovr_cnt[0] + ovr_cnt[1], 0);
        check("row5_write_y",      32'(wr_y[0]), 5);

        clear_counts();
        pulse(10'd6);
        wait_cycles(800);
        check("row6_select",  32'(sel[0]), 0);
        check("row6_writes",  wr_cnt[0], 640);
        check("row6_write_y", 32'(wr_y[1]), 6);
        check("row6_overrun", ovr_cnt[0] + ovr_cnt[1], 0);

        // Row beyond the visible area: swap only.
        clear_counts();
        pulse(10'd480);
        wait_cycles(20);
        check("row480_select", 32'(sel[0]), 1);
        check("row480_writes", wr_cnt[0] + wr_cnt[1], 0);
        check("row480_busy",   32'(busy_seen[0] | busy_seen[1]), 0);

        // Overrun: second pulse 300 cycles into the fill of row 7.
        clear_counts();
        pulse(10'd7);
        repeat (298) @(negedge Clk50);
        pulse(10'd8);
        wait_cycles(800);
        check("ovr_pulses_l2",   ovr_cnt[0], 1);
        check("ovr_pulses_l4",   ovr_cnt[1], 1);
        check("ovr_writes_l2",   wr_cnt[0], (300 - LAT0) + 640);
        check("ovr_writes_l4",   wr_cnt[1], (300 - LAT1) + 640);
        check("ovr_restart_x",   32'(first_x[0]), 0);
        check("ovr_select",      32'(sel[0]), 1);

        // Reset in the middle of a fill.
        clear_counts();
        pulse(10'd9);
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge Clk50);
            if (wr_en[0] === 1'b1 && wr_x[0] === 10'd100) found = 1;
        end
        check("rst_reached_x100", 32'(found), 1);
        @(posedge Clk50);
        #2 Reset = 1'b0;
        #1;
        check("rst_async_wen_l2", 32'(wr_en[0]), 0);
        check("rst_async_wen_l4", 32'(wr_en[1]), 0);
        check("rst_async_select", 32'(sel[0]), 0);
        repeat (3) @(negedge Clk50);
        Reset = 1'b1;
        clear_counts();
        wait_cycles(50);
        check("rst_no_resume_writes", wr_cnt[0] + wr_cnt[1], 0);
        check("rst_no_resume_busy",   32'(busy_seen[0] | busy_seen[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_fill_controller.md
# line_fill_controller

Write-side sequencer for the ping-pong row buffer in the 50 MHz domain. On each line-start pulse it swaps the buffers by toggling `select`, then fetches one full row of 4-bit palette indices from the pixel source. The source is the sprite/background compositor, which has fixed read latency. It streams those indices into the now-idle row buffer as `write_X`/`write_data`/`write_en`, so the VGA side reads row N while row N+1 is filled.

## Interface
- `H_PIXELS`, 640: pixels written per row; `write_X` runs 0..H_PIXELS-1.
- `V_LINES`, 480: visible rows; rows ≥ V_LINES are not filled.
- `SRC_LATENCY`, 2: cycles from `src_X`/`src_Y` valid to matching `src_data` valid; legal range 1..4.

- `Clk50`  in  1  system clock, the only clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse, already synchronous to `Clk50`: the display has begun a new row.
- `next_row`  in  10  row to be filled; sampled only on `line_start`.
- `src_data`  in  4  palette index from the pixel source, SRC_LATENCY cycles after request.
- `src_X`  out  10  pixel-source column request.
- `src_Y`  out  10  pixel-source row request.
- `write_en`  out  1  row-buffer write strobe.
- `write_X`  out  10  row-buffer write column.
- `write_Y`  out  10  row currently being filled, for debug and compositor use.
- `write_data`  out  4  row-buffer write data.
- `select`  out  1  buffer-swap control to the row buffer.
- `busy`  out  1  high in FILL or DRAIN.
- `overrun`  out  1  one-cycle pulse when a fill is aborted.

## Operation
- States: IDLE, FILL, DRAIN. All outputs are registered.
- IDLE + `line_start`:
  - toggle `select`;
  - latch `next_row` into `write_Y` and `src_Y`;
  - if latched row < V_LINES, go to FILL with issue counter = 0; otherwise stay IDLE with no writes.
- FILL:
  - each cycle, present `src_X` = issue counter, then increment;
  - push a valid bit and the column into a SRC_LATENCY-deep delay line;
  - after issuing column H_PIXELS-1, go to DRAIN.
- DRAIN: no new requests; exit to IDLE once the delay line is empty.
- Write port: when the delay-line output is valid, `write_en`=1, `write_X` = delayed column, `write_data` = `src_data`; otherwise `write_en`=0. `write_X`/`write_data` hold their last values when not writing.
- Overrun, i.e. `line_start` while in FILL or DRAIN:
  - pulse `overrun`;
  - flush the delay line, so no stale writes reach the new buffer;
  - toggle `select`, latch the new row and restart FILL at column 0, or go to IDLE if the row ≥ V_LINES.
- `write_en` is never high in the same cycle `select` changes.
- `src_X` is held at 0 when not in FILL.
- Counters are 10-bit and never wrap: the issue counter stops at H_PIXELS-1.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE;
  - `select`=0, `write_en`=0, `busy`=0, `overrun`=0;
  - `write_X`, `write_Y`, `write_data`, `src_X`, `src_Y` = 0;
  - delay line cleared.
- Reset mid-fill: all writes stop immediately; no partial resume after release.
- `line_start` sampled at cycle t:
  - `select` toggles, `busy`=1 and `src_X`=0 at t+1;
  - first write (`write_X`=0) at t+1+SRC_LATENCY;
  - last write (`write_X`=H_PIXELS-1) at t+SRC_LATENCY+H_PIXELS;
  - `busy`=0 at t+SRC_LATENCY+H_PIXELS+1.
- Throughput: one pixel per cycle, no bubbles.
- Full row time is H_PIXELS+SRC_LATENCY+1 cycles; the 1600-cycle line period at 50 MHz leaves margin.
- `overrun` is asserted at the cycle after the offending `line_start`, together with the `select` toggle.

## Test plan
- Reset then `line_start` with `next_row`=5, source returning `src_data` = `src_X[3:0]` (delayed 2 cycles):
  - `select` goes 0→1;
  - 640 consecutive writes, `write_X` 0..639, `write_data` = X mod 16, `write_Y`=5;
  - `busy` falls 643 cycles after the pulse.
- Two line starts 1600 cycles apart (rows 5, 6): `select` toggles each time; second fill has `write_Y`=6; `overrun` never asserted.
- `line_start` with `next_row`=480: `select` toggles, zero writes, `busy` stays 0.
- Second `line_start` 300 cycles into a fill:
  - `overrun` pulses once;
  - no write with `write_X`≥298 from the aborted row appears after the toggle;
  - new row restarts at `write_X`=0.
- `Reset` asserted at `write_X`=100 mid-fill: `write_en` drops asynchronously, `select`=0; after release, no writes until the next `line_start`.
- SRC_LATENCY=4 build: first write exactly 5 cycles after `line_start`; data alignment still X mod 16.
